// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the MiniMIPS32 pipeline controller: stall vector
// encoding, exception-code width and special codes, reset PC and FSM states.
package pipe_ctrl_pkg;

  // Stall vector: bit0 PC, bit1 IF, bit2 ID, bit3 EXE, bit4 MEM.
  localparam int unsigned STALL_W = 5;
  typedef logic [STALL_W-1:0] stall_t;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  // Legal stall values are thermometer codes: a stage stalls itself and
  // every stage upstream of it.
  localparam stall_t STALL_NONE = {NOSTOP, NOSTOP, NOSTOP, NOSTOP, NOSTOP};
  localparam stall_t STALL_ID   = {NOSTOP, NOSTOP, STOP,   STOP,   STOP};
  localparam stall_t STALL_EXE  = {NOSTOP, STOP,   STOP,   STOP,   STOP};
  localparam stall_t STALL_ALL  = {STOP,   STOP,   STOP,   STOP,   STOP};

  localparam int unsigned EXC_CODE_W = 5;
  typedef logic [EXC_CODE_W-1:0] exc_code_t;

  // Codes outside the architectural ExcCode range mark "no exception" and ERET.
  localparam exc_code_t EXC_NONE = 5'h10;
  localparam exc_code_t EXC_ERET = 5'h11;

  localparam int unsigned INST_ADDR_W = 32;
  typedef logic [INST_ADDR_W-1:0] inst_addr_t;

  localparam inst_addr_t PC_INIT = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle between pipe_ctrl (master) and the pipeline/CP0
// side (slave): stall requests, MEM-stage bus/exception status, and the
// stall/flush/redirect outputs.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic       stallreq_id;
  logic       stallreq_exe;
  logic       mem_dreq;
  logic       dbus_ack;
  exc_code_t  mem_exccode;
  inst_addr_t cp0_epc;
  stall_t     stall;
  logic       flush;
  inst_addr_t flush_pc;
  logic       dbus_err;

  modport master (
    input  stallreq_id, stallreq_exe, mem_dreq, dbus_ack, mem_exccode, cp0_epc,
    output stall, flush, flush_pc, dbus_err
  );

  modport slave (
    output stallreq_id, stallreq_exe, mem_dreq, dbus_ack, mem_exccode, cp0_epc,
    input  stall, flush, flush_pc, dbus_err
  );

endinterface

// File: rtl/pipe_ctrl_dbus_wait_timer.sv
// Counts cycles spent waiting for a data-bus acknowledge. A start loads 1,
// the count then advances every cycle until ack or clear, and o_timeout
// flags the last permitted wait cycle.
module pipe_ctrl_dbus_wait_timer #(
  parameter int unsigned DBUS_TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_start,
  input  logic i_ack,
  input  logic i_clear,
  output logic o_timeout
);

  localparam int unsigned WCNT_W = $clog2(DBUS_TIMEOUT);

  logic [WCNT_W-1:0] r_wcnt;

  // Wait counter: clear/ack dominate, start loads 1, a running count advances.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values regardless of statement order.
    if (i_clear || i_ack) begin
      r_wcnt <= '0;
    end else if (i_start) begin
      r_wcnt <= WCNT_W'(1);
    end else if (r_wcnt != '0) begin
      r_wcnt <= r_wcnt + WCNT_W'(1);
    end
  end

  assign o_timeout = (r_wcnt == WCNT_W'(DBUS_TIMEOUT - 1));

endmodule

// File: rtl/pipe_ctrl.sv
// MiniMIPS32 pipeline controller: arbitrates stall requests, holds the
// pipeline while a MEM-stage bus access is outstanding (with timeout), and
// sequences the one-cycle flush plus PC redirect for exceptions and ERET.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DBUS_TIMEOUT = 16,
  parameter inst_addr_t  EXC_VECTOR   = 32'hBFC0_0380
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  pipe_ctrl_if.master bus
);

  state_t     r_state;
  state_t     w_next_state;
  stall_t     w_stall;
  logic       w_dbus_err;
  logic       w_start;
  logic       w_clear;
  logic       w_timeout;
  logic       r_flush;
  inst_addr_t r_flush_pc;
  inst_addr_t w_flush_pc_nxt;

  pipe_ctrl_dbus_wait_timer #(
    .DBUS_TIMEOUT (DBUS_TIMEOUT)
  ) u_dbus_wait_timer (
    .i_clk     (cpu_clk_50M),
    .i_start   (w_start),
    .i_ack     (bus.dbus_ack),
    .i_clear   (w_clear),
    .o_timeout (w_timeout)
  );

  // Next state, stall arbitration, bus-error pulse and redirect target.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves one unassigned and no latch is inferred.
    w_next_state   = r_state;
    w_stall        = STALL_NONE;
    w_dbus_err     = 1'b0;
    w_start        = 1'b0;
    w_clear        = 1'b0;
    w_flush_pc_nxt = r_flush_pc;

    if (cpu_rst) begin
      // Reset aborts any wait or flush silently.
      w_next_state = ST_RUN;
      w_clear      = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.mem_exccode != EXC_NONE) begin
            w_stall        = STALL_ALL;
            w_next_state   = ST_FLUSH;
            w_flush_pc_nxt = (bus.mem_exccode == EXC_ERET) ? bus.cp0_epc : EXC_VECTOR;
          end else if (bus.mem_dreq && !bus.dbus_ack) begin
            w_stall      = STALL_ALL;
            w_start      = 1'b1;
            w_next_state = ST_DWAIT;
          end else if (bus.mem_dreq) begin
            // Single-cycle access completes without holding the pipe.
            w_stall = STALL_NONE;
          end else if (bus.stallreq_exe) begin
            w_stall = STALL_EXE;
          end else if (bus.stallreq_id) begin
            w_stall = STALL_ID;
          end
        end

        ST_DWAIT: begin
          // ID/EXE requests are covered by the full stall here.
          if (bus.dbus_ack) begin
            w_next_state = ST_RUN;
          end else if (w_timeout) begin
            w_stall        = STALL_ALL;
            w_dbus_err     = 1'b1;
            w_clear        = 1'b1;
            w_flush_pc_nxt = EXC_VECTOR;
            w_next_state   = ST_FLUSH;
          end else begin
            w_stall = STALL_ALL;
          end
        end

        ST_FLUSH: begin
          w_next_state = ST_RUN;
        end

        default: begin
          w_next_state = ST_RUN;
        end
      endcase
    end
  end

  // State, registered flush pulse and latched redirect target.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      r_state    <= ST_RUN;
      r_flush    <= 1'b0;
      r_flush_pc <= PC_INIT;
    end else begin
      r_state    <= w_next_state;
      r_flush    <= (w_next_state == ST_FLUSH);
      r_flush_pc <= w_flush_pc_nxt;
    end
  end

  // Reset forces the flush outputs to their idle values in the same cycle.
  assign bus.stall    = w_stall;
  assign bus.dbus_err = w_dbus_err;
  assign bus.flush    = r_flush & ~cpu_rst;
  assign bus.flush_pc = cpu_rst ? PC_INIT : r_flush_pc;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: each driven cycle pushes its expected
// outputs to a scoreboard; the negedge monitor pops and compares them.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [31:0] EV  = 32'hBFC0_0380;
  localparam logic [31:0] PI  = 32'hBFC0_0000;
  localparam logic [31:0] EPC = 32'hBFC0_0124;
  localparam logic [4:0]  S0  = 5'b00000;
  localparam logic [4:0]  SID = 5'b00111;
  localparam logic [4:0]  SEX = 5'b01111;
  localparam logic [4:0]  SAL = 5'b11111;
  localparam exc_code_t   EXC_SYS = 5'h08;
  localparam exc_code_t   EXC_OV  = 5'h0c;
  localparam exc_code_t   NO      = EXC_NONE;

  typedef struct packed {
    logic        rst;
    logic [4:0]  stall;
    logic        err;
    logic        flush;
    logic [31:0] pc;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  exp_t  exp_q[$];
  string tag_q[$];

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .DBUS_TIMEOUT (16),
    .EXC_VECTOR   (EV)
  ) dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs that cycle must show.
  task automatic cyc(input string tag, input logic r, input logic id, input logic exe,
                     input logic dreq, input logic ack, input exc_code_t exc,
                     input logic [4:0] e_stall, input logic e_err, input logic e_flush,
                     input logic [31:0] e_pc);
    exp_t e;
    rst              = r;
    bus.stallreq_id  = id;
    bus.stallreq_exe = exe;
    bus.mem_dreq     = dreq;
    bus.dbus_ack     = ack;
    bus.mem_exccode  = exc;
    e.rst   = r;
    e.stall = e_stall;
    e.err   = e_err;
    e.flush = e_flush;
    e.pc    = e_pc;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampling mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".stall"},    32'(bus.stall),    32'(e.stall));
      check({t, ".dbus_err"}, 32'(bus.dbus_err), 32'(e.err));
      check({t, ".flush"},    32'(bus.flush),    32'(e.flush));
      check({t, ".thermo"},   32'(((bus.stall + 5'd1) & bus.stall) == 5'd0), 32'd1);
      if (e.flush || e.rst) begin
        check({t, ".flush_pc"}, bus.flush_pc, e.pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst              = 1'b1;
    bus.stallreq_id  = 1'b0;
    bus.stallreq_exe = 1'b0;
    bus.mem_dreq     = 1'b0;
    bus.dbus_ack     = 1'b0;
    bus.mem_exccode  = NO;
    bus.cp0_epc      = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    // Reset dominates pending stall and exception requests.
    for (int i = 0; i < 3; i++) cyc("rst", 1, 0, 1, 0, 0, EXC_OV, S0, 0, 0, PI);
    cyc("idle", 0, 0, 0, 0, 0, NO, S0, 0, 0, 0);

    // Stall priority.
    cyc("st.id",   0, 1, 0, 0, 0, NO, SID, 0, 0, 0);
    cyc("st.exe",  0, 1, 1, 0, 0, NO, SEX, 0, 0, 0);
    cyc("st.drop", 0, 0, 0, 0, 0, NO, S0,  0, 0, 0);
    cyc("st.1cyc", 0, 1, 1, 1, 1, NO, S0,  0, 0, 0);

    // Data-bus wait, ack on the 4th cycle; ID request ignored while waiting.
    cyc("dw.req",  0, 0, 0, 1, 0, NO, SAL, 0, 0, 0);
    cyc("dw.w2",   0, 1, 0, 1, 0, NO, SAL, 0, 0, 0);
    cyc("dw.w3",   0, 1, 0, 1, 0, NO, SAL, 0, 0, 0);
    cyc("dw.ack",  0, 0, 0, 1, 1, NO, S0,  0, 0, 0);
    cyc("dw.post", 0, 0, 0, 0, 0, NO, S0,  0, 0, 0);

    // Timeout: no ack, error in cycle 16, flush next, inputs ignored in flush.
    for (int i = 1; i <= 15; i++) cyc("to.wait", 0, 0, 0, 1, 0, NO, SAL, 0, 0, 0);
    cyc("to.err",   0, 0, 0, 1, 0, NO, SAL, 1, 0, 0);
    cyc("to.flush", 0, 0, 1, 1, 0, NO, S0,  0, 1, EV);
    cyc("to.run",   0, 0, 0, 0, 0, NO, S0,  0, 0, 0);

    // Ack exactly in cycle 16 wins over the timeout.
    for (int i = 1; i <= 15; i++) cyc("ta.wait", 0, 0, 0, 1, 0, NO, SAL, 0, 0, 0);
    cyc("ta.ack",  0, 0, 0, 1, 1, NO, S0, 0, 0, 0);
    cyc("ta.post", 0, 0, 0, 0, 0, NO, S0, 0, 0, 0);

    // Exception then back-to-back ERET.
    cyc("ex.sys",    0, 0, 0, 0, 0, EXC_SYS, SAL, 0, 0, 0);
    cyc("ex.flush",  0, 0, 0, 0, 0, NO,      S0,  0, 1, EV);
    bus.cp0_epc = EPC;
    cyc("ex.eret",   0, 0, 0, 0, 0, EXC_ERET, SAL, 0, 0, 0);
    bus.cp0_epc = 32'h0;
    cyc("ex.eflush", 0, 0, 0, 0, 0, NO,       S0,  0, 1, EPC);

    // Exception beats a pending bus request; exception in FLUSH is ignored.
    cyc("ex.dreq",   0, 0, 0, 1, 0, EXC_SYS, SAL, 0, 0, 0);
    cyc("ex.ign",    0, 0, 1, 0, 0, EXC_OV,  S0,  0, 1, EV);
    cyc("ex.run",    0, 0, 0, 0, 0, NO,      S0,  0, 0, 0);

    // Reset in the 5th wait cycle aborts silently.
    for (int i = 1; i <= 4; i++) cyc("rd.wait", 0, 0, 0, 1, 0, NO, SAL, 0, 0, 0);
    cyc("rd.rst",  1, 0, 0, 1, 0, NO, S0,  0, 0, PI);
    cyc("rd.run",  0, 0, 0, 0, 0, NO, S0,  0, 0, 0);
    cyc("rd.id",   0, 1, 0, 0, 0, NO, SID, 0, 0, 0);
    cyc("rd.idle", 0, 0, 0, 0, 0, NO, S0,  0, 0, 0);

    check("sb.drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
